btn_gesture_decoder: RTL

Input-side counterpart to the LED/seven-segment output path: turns one raw push-button into classified, single-cycle gesture events (short press, double press, long press). Each event is a one-`clk` pulse, so control logic (start/stop toggles, mode select) consumes it directly, with no separate `debounce`/`onepulse` chain. The block synchronizes, debounces on a slow tick, and runs a gesture state machine. It also keeps an event counter that can be routed to the `SevenSegment` `nums` input.

---
 rtl/btn_gesture_decoder.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/btn_gesture_decoder.sv
// Push-button gesture decoder: sync, tick-based debounce, gesture FSM.
// Emits one-cycle short/double/long pulses and counts them.
module btn_gesture_decoder #(
    parameter int TICK_DIV   = 17,
    parameter int DB_LEN     = 4,
    parameter int LONG_TICKS = 500,
    parameter int DBL_TICKS  = 250
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_raw,
    output logic        held,
    output logic        short_pulse,
    output logic        double_pulse,
    output logic        long_pulse,
    output logic [2:0]  state,
    output logic [15:0] event_count
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS1    = 3'd1,
        WAIT2     = 3'd2,
        PRESS2    = 3'd3,
        LONG_HOLD = 3'd4
    } state_t;

    localparam logic [11:0] LONG_T = 12'(LONG_TICKS);
    localparam logic [11:0] DBL_T  = 12'(DBL_TICKS);

    state_t              st;
    state_t              st_nxt;
    logic [TICK_DIV-1:0] presc;
    logic [1:0]          sync_q;
    logic [DB_LEN-1:0]   db_sh;
    logic                held_q;
    logic [11:0]         timer;
    logic                tick;
    logic                rise;
    logic                fall;
    logic                sp_nxt;
    logic                dp_nxt;
    logic                lp_nxt;

    assign tick  = &presc;
    assign rise  = held & ~held_q;
    assign fall  = ~held & held_q;
    assign state = st;

    always_ff @(posedge clk) begin
        if (rst) begin
            presc  <= '0;
            sync_q <= '0;
            db_sh  <= '0;
            held   <= 1'b0;
            held_q <= 1'b0;
        end else begin
            presc  <= presc + TICK_DIV'(1);
            sync_q <= {sync_q[0], btn_raw};
            if (tick)
                db_sh <= DB_LEN'({db_sh, sync_q[1]});
            if (&db_sh)
                held <= 1'b1;
            else if (~|db_sh)
                held <= 1'b0;
            held_q <= held;
        end
    end

    // Timer restarts on every state change; the clear beats a same-cycle tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer <= '0;
        end else if (st_nxt != st) begin
            timer <= '0;
        end else if (tick && timer != 12'hFFF) begin
            timer <= timer + 12'd1;
        end
    end

    always_comb begin
        st_nxt = st;
        sp_nxt = 1'b0;
        dp_nxt = 1'b0;
        lp_nxt = 1'b0;
        unique case (st)
            IDLE: begin
                if (rise)
                    st_nxt = PRESS1;
            end
            PRESS1: begin
                if (fall) begin
                    st_nxt = WAIT2;
                end else if (timer == LONG_T) begin
                    st_nxt = LONG_HOLD;
                    lp_nxt = 1'b1;
                end
            end
            WAIT2: begin
                if (rise) begin
                    st_nxt = PRESS2;
                end else if (timer == DBL_T) begin
                    st_nxt = IDLE;
                    sp_nxt = 1'b1;
                end
            end
            PRESS2: begin
                if (fall) begin
                    st_nxt = IDLE;
                    dp_nxt = 1'b1;
                end else if (timer == LONG_T) begin
                    st_nxt = LONG_HOLD;
                    dp_nxt = 1'b1;
                end
            end
            LONG_HOLD: begin
                if (fall)
                    st_nxt = IDLE;
            end
            default: st_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st           <= IDLE;
            short_pulse  <= 1'b0;
            double_pulse <= 1'b0;
            long_pulse   <= 1'b0;
            event_count  <= '0;
        end else begin
            st           <= st_nxt;
            short_pulse  <= sp_nxt;
            double_pulse <= dp_nxt;
            long_pulse   <= lp_nxt;
            if (sp_nxt | dp_nxt | lp_nxt)
                event_count <= event_count + 16'd1;
        end
    end

endmodule
